// File: rtl/instr_encode_loader_if.sv
// Descriptor stream from the host plus the instruction-memory write port.
// The loader sits on the slave side; the host/test side uses master.
interface instr_encode_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [4:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_last, op_sel, rs, rt, rd, shamt, imm, target,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_last, op_sel, rs, rt, rd, shamt, imm, target,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes compact instruction descriptors into MIPS words and writes them to
// sequential instruction-memory addresses while holding the CPU.
module instr_encode_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_encode_loader_if.slave  bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W:0]       word_count
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL      = CW'(DEPTH);
  localparam logic [ADDR_W:0] LAST_SLOT = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t      state;
  logic        fin;
  logic        ready;
  logic        accept;
  logic        known;
  logic [31:0] word;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] i);
    return {op, s, t, i};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, s, t, d, sh, fn};
  endfunction

  // fin marks that the session's final beat has been taken; the state
  // machine leaves LOAD on the edge that closes that beat's write cycle.
  assign ready        = (state == LOAD) && !fin && (word_count < FULL);
  assign accept       = ready && bus.in_valid;
  assign bus.in_ready = ready;
  assign cpu_hold     = (state == LOAD);
  assign done         = (state == DONE);

  always_comb begin
    known = 1'b1;
    word  = '0;
    case (bus.op_sel)
      5'd0:  word = itype(6'h23, bus.rs, bus.rt, bus.imm);
      5'd1:  word = itype(6'h2B, bus.rs, bus.rt, bus.imm);
      5'd2:  word = itype(6'h0F, 5'd0,   bus.rt, bus.imm);
      5'd3:  word = itype(6'h08, bus.rs, bus.rt, bus.imm);
      5'd4:  word = itype(6'h09, bus.rs, bus.rt, bus.imm);
      5'd5:  word = itype(6'h0C, bus.rs, bus.rt, bus.imm);
      5'd6:  word = itype(6'h0A, bus.rs, bus.rt, bus.imm);
      5'd7:  word = itype(6'h0B, bus.rs, bus.rt, bus.imm);
      5'd8:  word = itype(6'h04, bus.rs, bus.rt, bus.imm);
      5'd9:  word = {6'h02, bus.target};
      5'd10: word = {6'h03, bus.target};
      5'd11: word = rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h20);
      5'd12: word = rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h21);
      5'd13: word = rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h22);
      5'd14: word = rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h23);
      5'd15: word = rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h24);
      5'd16: word = rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h25);
      5'd17: word = rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h26);
      5'd18: word = rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h27);
      5'd19: word = rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h2A);
      5'd20: word = rtype(bus.rs, bus.rt, bus.rd, 5'd0, 6'h2B);
      5'd21: word = rtype(5'd0,   bus.rt, bus.rd, bus.shamt, 6'h00);
      5'd22: word = rtype(5'd0,   bus.rt, bus.rd, bus.shamt, 6'h02);
      5'd23: word = rtype(5'd0,   bus.rt, bus.rd, bus.shamt, 6'h03);
      5'd24: word = rtype(bus.rs, 5'd0,   5'd0,   5'd0, 6'h08);
      5'd25: word = rtype(bus.rs, 5'd0,   bus.rd, 5'd0, 6'h09);
      default: known = 1'b0;
    endcase
  end

  // Unknown mnemonics are consumed without a write so the address stays dense.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      fin            <= 1'b0;
      err            <= 1'b0;
      word_count     <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= LOAD;
            fin           <= 1'b0;
            err           <= 1'b0;
            word_count    <= '0;
            bus.imem_addr <= '0;
          end
        end
        LOAD: begin
          if (fin) state <= DONE;
          if (accept) begin
            fin <= bus.in_last || (known && (word_count == LAST_SLOT));
            if (known) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_count[ADDR_W-1:0];
              bus.imem_wdata <= word;
              word_count     <= word_count + 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
